// File: rtl/card_slot_fetcher.sv
// card_slot_fetcher: once per frame, reads ten card-slot words and the
// win/loss status word from data memory over a single-outstanding req/ack
// port into a working buffer, then commits them atomically into the
// display table that the renderer queries with a one-cycle lookup.
// Optional build macro: FETCH_TIMEOUT_EN adds a per-request ack timeout
// and the sticky timeout_flag; without it REQ waits indefinitely.
module card_slot_fetcher #(
`ifdef FETCH_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES = 255,
`endif
    parameter int unsigned NUM_SLOTS   = 10,
    parameter int unsigned BASE_ADDR   = 16,
    parameter int unsigned STATUS_ADDR = 26,
    parameter int unsigned CARD_COUNT  = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic [3:0]  slot_sel,
    output logic [31:0] card_index,
    output logic        slot_valid,
    output logic [1:0]  win_loss,
    output logic        busy,
    output logic [7:0]  overrun_count,
    output logic        timeout_flag
);

    typedef enum logic [1:0] {IDLE, REQ, COMMIT} state_t;

    localparam logic [3:0] LAST_PTR = 4'(NUM_SLOTS);

    state_t               state;
    logic [3:0]           ptr;
    logic [31:0]          work_index [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] work_valid;
    logic [1:0]           work_status;
    logic [31:0]          disp_index [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] disp_valid;

    logic [31:0] req_addr;
    logic        rdata_in_range;
    logic [1:0]  rdata_status;
    logic        timeout_hit;
    logic        take_word;

    // Address of the word at ptr, and classification of the returned data
    always_comb begin
        req_addr       = (ptr < LAST_PTR) ? (32'(BASE_ADDR) + 32'(ptr)) : 32'(STATUS_ADDR);
        rdata_in_range = (mem_rdata < 32'(CARD_COUNT));
        rdata_status   = (mem_rdata[1:0] == 2'b11) ? 2'b00 : mem_rdata[1:0];
        take_word      = mem_req && (mem_ack || timeout_hit);
    end

`ifdef FETCH_TIMEOUT_EN
    logic [31:0] wait_count;

    assign timeout_hit = mem_req && !mem_ack && (wait_count == TIMEOUT_CYCLES - 1);

    // Per-request ack wait counter and sticky timeout flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_count   <= '0;
            timeout_flag <= 1'b0;
        end else if (state == REQ && mem_req && !mem_ack) begin
            if (timeout_hit) begin
                wait_count   <= '0;
                timeout_flag <= 1'b1;
            end else begin
                wait_count <= wait_count + 32'd1;
            end
        end else begin
            wait_count <= '0;
        end
    end
`else
    assign timeout_hit  = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    // Fetch sequencer: request each word, fill the working buffer, commit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            ptr           <= '0;
            mem_req       <= 1'b0;
            mem_addr      <= '0;
            busy          <= 1'b0;
            overrun_count <= '0;
            work_valid    <= '0;
            work_status   <= 2'b00;
            disp_valid    <= '0;
            win_loss      <= 2'b00;
            for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                work_index[i] <= '0;
                disp_index[i] <= '0;
            end
        end else begin
            if (frame_start && state != IDLE && overrun_count != 8'hFF)
                overrun_count <= overrun_count + 8'd1;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state <= REQ;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end
                end
                REQ: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_addr <= req_addr;
                    end else if (take_word) begin
                        mem_req <= 1'b0;
                        if (ptr < LAST_PTR) begin
                            work_index[ptr] <= (mem_ack && rdata_in_range) ? mem_rdata : 32'd0;
                            work_valid[ptr] <= mem_ack && rdata_in_range;
                        end else begin
                            work_status <= mem_ack ? rdata_status : 2'b00;
                        end
                        if (ptr == LAST_PTR)
                            state <= COMMIT;
                        else
                            ptr <= ptr + 4'd1;
                    end
                end
                COMMIT: begin
                    for (int i = 0; i < int'(NUM_SLOTS); i++)
                        disp_index[i] <= work_index[i];
                    disp_valid <= work_valid;
                    win_loss   <= work_status;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Registered renderer lookup: one cycle from slot_sel to card_index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            card_index <= '0;
            slot_valid <= 1'b0;
        end else if (slot_sel < LAST_PTR) begin
            card_index <= disp_index[slot_sel];
            slot_valid <= disp_valid[slot_sel];
        end else begin
            card_index <= '0;
            slot_valid <= 1'b0;
        end
    end

endmodule
